bsg_lru_pseudo_tree_ctrl: RTL and testbench
===========================================

# bsg_lru_pseudo_tree_ctrl

Per-set pseudo-LRU replacement controller for set-associative caches and TLBs. It keeps one binary-tree LRU vector per set, updates it on hits ("touch") and on allocation, and offers one victim way per allocation request over a valid/yumi handshake. Its update path uses the same one-hot path decode as the pseudo-tree decoder: data bits are applied under the path mask. Its victim path is the inverse tree walk.

## Interface
- `ways_p`, 16: associativity; power of two, ≥2; tree has `ways_p-1` nodes.
- `sets_p`, 8: number of sets; ≥1.
- `clk_i` in 1: clock.
- `reset_n_i` in 1: asynchronous, active-low reset. One clock domain; reset polarity and synchronicity are fixed.
- `touch_v_i` in 1: hit update strobe; always accepted.
- `touch_set_i` in `lg(sets_p)`: set index of the hit.
- `touch_way_i` in `lg(ways_p)`: way that hit.
- `alloc_v_i` in 1: victim request.
- `alloc_set_i` in `lg(sets_p)`: set needing a victim.
- `alloc_ready_o` out 1: request accepted when `alloc_v_i & alloc_ready_o`.
- `alloc_v_o` out 1: victim valid.
- `alloc_way_o` out `lg(ways_p)`: victim way.
- `alloc_yumi_i` in 1: consumer takes the victim; legal only while `alloc_v_o`=1.

## Operation
- **Storage:** `sets_p` × `(ways_p-1)` flop vectors `lru[s]`.
  - Node n has children 2n+1 (bit 0) and 2n+2 (bit 1).
  - Node bit = direction of the less-recently-used subtree.
- **Decode of way w:** walk from node 0 using w's bits MSB first.
  - Every node on the path is masked.
  - Each masked node is written with the inverse of the bit taken at that node, so it points away from w.
  - All other nodes are unchanged.
- **Victim of set s:** start at node 0 and follow `lru[s]` bits to a leaf. The bits taken, MSB first, form the way.
- **Touch:** on `touch_v_i`, `lru[touch_set_i]` is updated with the decode of `touch_way_i`.
- **FSM:** two states.
  - IDLE: `alloc_ready_o`=1, `alloc_v_o`=0. When `alloc_v_i`=1, latch `alloc_set_i` and go to OFFER.
  - OFFER: `alloc_ready_o`=0, `alloc_v_o`=1. Hold while `alloc_yumi_i`=0. When `alloc_yumi_i`=1, apply the decode of the offered way to the latched set and return to IDLE.
- **Victim sampling:** the victim is computed in the acceptance cycle from `lru` including any same-cycle touch (touch forwarded). It is registered into `alloc_way_o` and then held stable for the whole OFFER, even if touches change that set.
- **Simultaneous touch and yumi:**
  - Same set: the touch is applied first, then the yumi decode. The yumi value wins on nodes masked by both.
  - Different sets: both updates are applied independently.
- **Back-to-back:** no new request is accepted in the yumi cycle. IDLE is re-entered the next cycle.
- **Input checks:** an out-of-range set index is illegal; bench asserts on it. `alloc_yumi_i` without `alloc_v_o` is ignored and asserted in simulation.

## Timing
- **Reset** (async assert, clocked deassert):
  - all `lru`=0, so the victim of every set is way 0;
  - FSM = IDLE;
  - `alloc_ready_o`=1, `alloc_v_o`=0, `alloc_way_o`=0.
- **Mid-operation reset:** reset during OFFER drops `alloc_v_o` immediately (combinationally from the async clear). The pending offer is discarded.
- **Touch latency:** 1 cycle. A touch at edge t affects any victim computed from cycle t+1, and also the victim of an alloc accepted in cycle t (forwarding).
- **Alloc latency:** accept at edge t → `alloc_v_o`=1 from t+1. Minimum two cycles per allocation.
- **Yumi update:** the update from yumi at edge t is visible from t+1.
- **Combinational paths:**
  - `alloc_v_o`, `alloc_ready_o` and `alloc_way_o` are driven from registers only.
  - No combinational path from any input to any output.

## Test plan
Bench uses `ways_p`=16, `sets_p`=4.
1. **Initial victims and rotation:** reset, then three alloc/yumi sequences on set 0 → ways 0, 8, 4. After each yumi, nodes on the offered path point away from that way.
2. **Set isolation:** touch set 1 way 0, then alloc set 1 → way 8. Alloc set 0 → way 0 (set 0 unaffected).
3. **Sequential touches:** touch set 2 ways 0,1,…,15 on consecutive cycles, then alloc set 2 → way 0. Touch way 0, then alloc → way 8.
4. **Backpressure and held victim:** alloc set 3 (victim 0) and hold `alloc_yumi_i`=0 for 3 cycles while touching set 3 way 0 each cycle. Required: `alloc_way_o` stays 0, `alloc_ready_o`=0 and `alloc_v_o`=1 throughout. The yumi then completes.
5. **Touch/yumi collision:** on set 0 after reset, offer way 0. In the same cycle, yumi and touch way 15. Required: node 0 = 1 (yumi wins); the next victim comes from the right subtree with nodes 2, 6 and 14 per touch way 15, i.e. way 8. Also check an acceptance-cycle touch of way 0 → offered way 8.
6. **Reset mid-offer:** pulse `reset_n_i` low mid-cycle during OFFER. Required: `alloc_v_o` falls before the next edge; after release `alloc_ready_o`=1 and every set's victim = 0.

Source files
------------

// File: rtl/bsg_lru_pseudo_tree_ctrl_if.sv
// Touch and victim-allocation signals of the pseudo-tree LRU controller.
// The controller sits on the slave side; the cache/TLB pipeline is the master.
interface bsg_lru_pseudo_tree_ctrl_if #(
    parameter int ways_p = 16,
    parameter int sets_p = 8
);
    localparam int lg_ways_lp = $clog2(ways_p);
    localparam int lg_sets_lp = (sets_p > 1) ? $clog2(sets_p) : 1;

    logic                  touch_v_i;
    logic [lg_sets_lp-1:0] touch_set_i;
    logic [lg_ways_lp-1:0] touch_way_i;
    logic                  alloc_v_i;
    logic [lg_sets_lp-1:0] alloc_set_i;
    logic                  alloc_ready_o;
    logic                  alloc_v_o;
    logic [lg_ways_lp-1:0] alloc_way_o;
    logic                  alloc_yumi_i;

    modport slave (
        input  touch_v_i, touch_set_i, touch_way_i,
        input  alloc_v_i, alloc_set_i, alloc_yumi_i,
        output alloc_ready_o, alloc_v_o, alloc_way_o
    );

    modport master (
        output touch_v_i, touch_set_i, touch_way_i,
        output alloc_v_i, alloc_set_i, alloc_yumi_i,
        input  alloc_ready_o, alloc_v_o, alloc_way_o
    );
endinterface

// File: rtl/bsg_lru_pseudo_tree_ctrl.sv
// Per-set binary-tree pseudo-LRU: touches update in 1 cycle, a victim is offered the cycle
// after acceptance and held (ready low) until yumi; outputs are registered only.
module bsg_lru_pseudo_tree_ctrl #(
    parameter int ways_p = 16,
    parameter int sets_p = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    bsg_lru_pseudo_tree_ctrl_if.slave   ctrl
);
    localparam int lg_ways_lp = $clog2(ways_p);
    localparam int lg_sets_lp = (sets_p > 1) ? $clog2(sets_p) : 1;
    localparam int nodes_lp   = ways_p - 1;

    typedef logic [nodes_lp-1:0]   tree_t;
    typedef logic [lg_ways_lp-1:0] way_t;
    typedef logic [lg_sets_lp-1:0] set_t;

    typedef struct packed {
        tree_t mask;
        tree_t data;
    } path_t;

    typedef enum logic {IDLE, OFFER} state_t;

    // Nodes on the path of w are masked and written to point away from w.
    function automatic path_t path_decode(way_t w);
        path_t p;
        way_t  node;
        p    = '0;
        node = '0;
        for (int l = 0; l < lg_ways_lp; l++) begin
            p.mask[node] = 1'b1;
            p.data[node] = ~w[lg_ways_lp-1-l];
            node = (node << 1) + way_t'(1) + way_t'(w[lg_ways_lp-1-l]);
        end
        return p;
    endfunction

    function automatic tree_t apply_path(tree_t row, path_t p);
        return (row & ~p.mask) | (p.data & p.mask);
    endfunction

    function automatic way_t victim_of(tree_t row);
        way_t v;
        way_t node;
        v    = '0;
        node = '0;
        for (int l = 0; l < lg_ways_lp; l++) begin
            v[lg_ways_lp-1-l] = row[node];
            node = (node << 1) + way_t'(1) + way_t'(row[node]);
        end
        return v;
    endfunction

    tree_t  lru_q [sets_p];
    tree_t  lru_d [sets_p];
    state_t state_q, state_d;
    set_t   set_q, set_d;
    way_t   way_q, way_d;
    logic   yumi_fire;
    tree_t  fwd_row;

    // Touch lands first so a same-set yumi overrides it on shared nodes, and so an
    // acceptance in this cycle sees the touch.
    always_comb begin
        for (int s = 0; s < sets_p; s++) begin
            lru_d[s] = lru_q[s];
        end
        if (ctrl.touch_v_i) begin
            lru_d[ctrl.touch_set_i] = apply_path(lru_q[ctrl.touch_set_i],
                                                 path_decode(ctrl.touch_way_i));
        end
        fwd_row = lru_d[ctrl.alloc_set_i];
        if (yumi_fire) begin
            lru_d[set_q] = apply_path(lru_d[set_q], path_decode(way_q));
        end
    end

    always_comb begin
        state_d   = state_q;
        set_d     = set_q;
        way_d     = way_q;
        yumi_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (ctrl.alloc_v_i) begin
                    state_d = OFFER;
                    set_d   = ctrl.alloc_set_i;
                    way_d   = victim_of(fwd_row);
                end
            end
            OFFER: begin
                if (ctrl.alloc_yumi_i) begin
                    state_d   = IDLE;
                    yumi_fire = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            set_q   <= '0;
            way_q   <= '0;
            for (int s = 0; s < sets_p; s++) begin
                lru_q[s] <= '0;
            end
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            way_q   <= way_d;
            for (int s = 0; s < sets_p; s++) begin
                lru_q[s] <= lru_d[s];
            end
        end
    end

    assign ctrl.alloc_ready_o = (state_q == IDLE);
    assign ctrl.alloc_v_o     = (state_q == OFFER);
    assign ctrl.alloc_way_o   = way_q;

    // Yumi with no victim on offer is dropped by the FSM; flag it in simulation.
    a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        ctrl.alloc_yumi_i |-> ctrl.alloc_v_o);
endmodule

// File: tb/tb_bsg_lru_pseudo_tree_ctrl.sv
// Directed bench for bsg_lru_pseudo_tree_ctrl with 16 ways and 4 sets.
module tb_bsg_lru_pseudo_tree_ctrl;
    localparam int WAYS = 16;
    localparam int SETS = 4;
    localparam int LGW  = 4;
    localparam int LGS  = 2;

    logic clk_i = 1'b0;
    logic reset_n_i;
    always #5 clk_i = ~clk_i;

    bsg_lru_pseudo_tree_ctrl_if #(.ways_p(WAYS), .sets_p(SETS)) bus();

    bsg_lru_pseudo_tree_ctrl #(.ways_p(WAYS), .sets_p(SETS)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .ctrl      (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        bus.touch_v_i    = 1'b0;
        bus.touch_set_i  = '0;
        bus.touch_way_i  = '0;
        bus.alloc_v_i    = 1'b0;
        bus.alloc_set_i  = '0;
        bus.alloc_yumi_i = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset_n_i = 1'b0;
        step();
        step();
        reset_n_i = 1'b1;
        step();
    endtask

    task automatic touch(input int s, input int w);
        assert (s < SETS);
        bus.touch_v_i   = 1'b1;
        bus.touch_set_i = LGS'(s);
        bus.touch_way_i = LGW'(w);
        step();
        bus.touch_v_i   = 1'b0;
    endtask

    task automatic accept(input int s, input int exp_way, input string tag);
        int budget;
        assert (s < SETS);
        budget = 0;
        while (bus.alloc_ready_o !== 1'b1 && budget < 10) begin
            step();
            budget++;
        end
        n_cmp++;
        if (bus.alloc_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL %s ready: got %b want 1", tag, bus.alloc_ready_o);
        end
        bus.alloc_v_i   = 1'b1;
        bus.alloc_set_i = LGS'(s);
        step();
        bus.alloc_v_i   = 1'b0;
        n_cmp++;
        if (bus.alloc_v_o !== 1'b1) begin
            n_err++;
            $display("FAIL %s v_o: got %b want 1", tag, bus.alloc_v_o);
        end
        n_cmp++;
        if (bus.alloc_way_o !== LGW'(exp_way)) begin
            n_err++;
            $display("FAIL %s way: got %0d want %0d", tag, bus.alloc_way_o, exp_way);
        end
    endtask

    task automatic yumi();
        if (bus.alloc_v_o === 1'b1) begin
            bus.alloc_yumi_i = 1'b1;
            step();
            bus.alloc_yumi_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if (bus.alloc_ready_o !== 1'b1 || bus.alloc_v_o !== 1'b0 || bus.alloc_way_o !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got ready=%b v=%b way=%0d want 1 0 0",
                     bus.alloc_ready_o, bus.alloc_v_o, bus.alloc_way_o);
        end
        for (int s = 0; s < SETS; s++) begin
            n_cmp++;
            if (dut.lru_q[s] !== 15'h0) begin
                n_err++;
                $display("FAIL reset_lru set %0d: got %h want 0000", s, dut.lru_q[s]);
            end
        end
    endtask

    task automatic test_rotation();
        int exp_way [3] = '{0, 8, 4};
        int exp_lru [3] = '{'h008B, 'h08AE, 'h0ABD};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            accept(0, exp_way[i], "rotation");
            yumi();
            n_cmp++;
            if (dut.lru_q[0] !== 15'(exp_lru[i])) begin
                n_err++;
                $display("FAIL rotation_lru step %0d: got %h want %h", i, dut.lru_q[0], 15'(exp_lru[i]));
            end
        end
    endtask

    task automatic test_set_isolation();
        apply_reset();
        touch(1, 0);
        accept(1, 8, "iso_set1");
        yumi();
        accept(0, 0, "iso_set0");
        yumi();
    endtask

    task automatic test_sequential_touch();
        apply_reset();
        for (int w = 0; w < WAYS; w++) touch(2, w);
        accept(2, 0, "seq_all");
        yumi();
        touch(2, 0);
        accept(2, 8, "seq_after0");
        yumi();
    endtask

    task automatic test_backpressure();
        apply_reset();
        accept(3, 0, "bp_accept");
        for (int c = 0; c < 3; c++) begin
            bus.touch_v_i   = 1'b1;
            bus.touch_set_i = LGS'(3);
            bus.touch_way_i = LGW'(0);
            step();
            n_cmp++;
            if (bus.alloc_way_o !== 4'd0 || bus.alloc_ready_o !== 1'b0 || bus.alloc_v_o !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold cycle %0d: got way=%0d ready=%b v=%b want 0 0 1",
                         c, bus.alloc_way_o, bus.alloc_ready_o, bus.alloc_v_o);
            end
        end
        bus.touch_v_i = 1'b0;
        yumi();
        n_cmp++;
        if (bus.alloc_v_o !== 1'b0 || bus.alloc_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL bp_done: got v=%b ready=%b want 0 1", bus.alloc_v_o, bus.alloc_ready_o);
        end
        accept(3, 8, "bp_next");
        yumi();
    endtask

    task automatic test_collision();
        apply_reset();
        accept(0, 0, "coll_offer");
        bus.alloc_yumi_i = 1'b1;
        bus.touch_v_i    = 1'b1;
        bus.touch_set_i  = LGS'(0);
        bus.touch_way_i  = LGW'(15);
        step();
        bus.alloc_yumi_i = 1'b0;
        bus.touch_v_i    = 1'b0;
        n_cmp++;
        if (dut.lru_q[0] !== 15'h008B) begin
            n_err++;
            $display("FAIL coll_lru: got %h want 008b", dut.lru_q[0]);
        end
        accept(0, 8, "coll_next");
        yumi();
        apply_reset();
        bus.alloc_v_i   = 1'b1;
        bus.alloc_set_i = LGS'(0);
        bus.touch_v_i   = 1'b1;
        bus.touch_set_i = LGS'(0);
        bus.touch_way_i = LGW'(0);
        step();
        bus.alloc_v_i = 1'b0;
        bus.touch_v_i = 1'b0;
        n_cmp++;
        if (bus.alloc_v_o !== 1'b1 || bus.alloc_way_o !== 4'd8) begin
            n_err++;
            $display("FAIL coll_forward: got v=%b way=%0d want 1 8", bus.alloc_v_o, bus.alloc_way_o);
        end
        yumi();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        accept(0, 0, "b2b_first");
        bus.alloc_yumi_i = 1'b1;
        bus.alloc_v_i    = 1'b1;
        bus.alloc_set_i  = LGS'(0);
        step();
        bus.alloc_yumi_i = 1'b0;
        n_cmp++;
        if (bus.alloc_v_o !== 1'b0 || bus.alloc_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_gap: got v=%b ready=%b want 0 1", bus.alloc_v_o, bus.alloc_ready_o);
        end
        step();
        bus.alloc_v_i = 1'b0;
        n_cmp++;
        if (bus.alloc_v_o !== 1'b1 || bus.alloc_way_o !== 4'd8) begin
            n_err++;
            $display("FAIL b2b_second: got v=%b way=%0d want 1 8", bus.alloc_v_o, bus.alloc_way_o);
        end
        yumi();
    endtask

    task automatic test_reset_mid_offer();
        apply_reset();
        touch(1, 0);
        accept(1, 8, "mid_offer");
        #2;
        reset_n_i = 1'b0;
        #1;
        n_cmp++;
        if (bus.alloc_v_o !== 1'b0) begin
            n_err++;
            $display("FAIL mid_drop: got v=%b want 0", bus.alloc_v_o);
        end
        step();
        reset_n_i = 1'b1;
        step();
        n_cmp++;
        if (bus.alloc_ready_o !== 1'b1 || bus.alloc_v_o !== 1'b0) begin
            n_err++;
            $display("FAIL mid_release: got ready=%b v=%b want 1 0", bus.alloc_ready_o, bus.alloc_v_o);
        end
        for (int s = 0; s < SETS; s++) begin
            accept(s, 0, "mid_victim");
            yumi();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        reset_n_i = 1'b0;
        test_reset();
        test_rotation();
        test_set_isolation();
        test_sequential_touch();
        test_backpressure();
        test_collision();
        test_back_to_back();
        test_reset_mid_offer();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
